// File: rtl/stage_sequencer.sv
// Instruction stage sequencer: gathers immediates, latches the condition once at
// instruction start, then steps the ALU through the enabled stages and their repeats.
module stage_sequencer #(
   parameter int NUM_STAGES    = 4,
   parameter int REPEAT_BITS   = 3,
   parameter int NUM_IMM_WORDS = 2,
   localparam int SB = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
   localparam int IB = $clog2(NUM_IMM_WORDS + 1)
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              inst_valid,
   output logic                              inst_done,
   output logic                              skipped,
   input  logic [NUM_STAGES-1:0]             stage_en,
   input  logic [NUM_STAGES*REPEAT_BITS-1:0] stage_repeat,
   input  logic [NUM_STAGES-1:0]             stage_needs_imm,
   input  logic [IB-1:0]                     imm_words,
   output logic                              load_imm,
   input  logic                              imm_word_loaded,
   input  logic                              use_cc,
   input  logic [3:0]                        cc,
   input  logic                              flag_c,
   input  logic                              flag_v,
   input  logic                              flag_s,
   input  logic                              flag_z,
   input  logic                              ext_wait,
   input  logic                              op_done,
   output logic [SB-1:0]                     stage,
   output logic [REPEAT_BITS-1:0]            pass_index,
   output logic                              first_pass,
   output logic                              last_pass,
   output logic                              execute,
   output logic                              busy
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [SB-1:0]          stage_q, stage_d;
   logic [REPEAT_BITS-1:0] pass_q, pass_d;
   logic [IB-1:0]          imm_count_q, imm_count_d;
   logic                   cc_ok_q, cc_ok_d;

   logic [SB-1:0]          first_stage, next_stage;
   logic                   next_found;
   logic [REPEAT_BITS-1:0] rep_cur;
   logic                   needs_cur;
   logic                   imm_ready;

   function automatic logic cc_eval(input logic [3:0] code, input logic c, input logic v,
                                    input logic s, input logic z);
      logic base;
      case (code[2:0])
         3'd1:    base = z;
         3'd2:    base = s;
         3'd3:    base = c;
         3'd4:    base = c && !z;
         3'd5:    base = v;
         3'd6:    base = v && !z;
         default: base = 1'b1;
      endcase
      return base ^ code[3];
   endfunction

   // Scanning downward leaves the lowest qualifying index in each result.
   always_comb begin
      first_stage = '0;
      next_stage  = '0;
      next_found  = 1'b0;
      rep_cur     = '0;
      needs_cur   = 1'b0;
      for (int s = NUM_STAGES - 1; s >= 0; s--) begin
         if (stage_en[s]) first_stage = SB'(s);
         if (stage_en[s] && (SB'(s) > stage_q)) begin
            next_stage = SB'(s);
            next_found = 1'b1;
         end
         if (SB'(s) == stage_q) begin
            rep_cur   = stage_repeat[s*REPEAT_BITS +: REPEAT_BITS];
            needs_cur = stage_needs_imm[s];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      stage_d     = stage_q;
      pass_d      = pass_q;
      imm_count_d = imm_count_q;
      cc_ok_d     = cc_ok_q;
      inst_done   = 1'b0;
      skipped     = 1'b0;
      execute     = 1'b0;
      imm_ready   = (imm_count_q == imm_words);
      load_imm    = reset_n && inst_valid && (imm_count_q < imm_words);

      if (load_imm && imm_word_loaded) imm_count_d = imm_count_q + IB'(1);

      case (state_q)
         IDLE: begin
            if (inst_valid) begin
               cc_ok_d = !use_cc || cc_eval(cc, flag_c, flag_v, flag_s, flag_z);
               stage_d = first_stage;
               pass_d  = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (!inst_valid) begin
               state_d     = IDLE;
               imm_count_d = '0;
               stage_d     = '0;
               pass_d      = '0;
            end else if (!cc_ok_q || (stage_en == '0)) begin
               // Skip only once every immediate word has been drained.
               if (imm_ready) begin
                  inst_done   = 1'b1;
                  skipped     = 1'b1;
                  state_d     = IDLE;
                  imm_count_d = '0;
                  stage_d     = '0;
                  pass_d      = '0;
               end
            end else begin
               execute = !ext_wait && !(needs_cur && !imm_ready);
               if (execute && op_done) begin
                  if (pass_q < rep_cur) begin
                     pass_d = pass_q + REPEAT_BITS'(1);
                  end else if (next_found) begin
                     stage_d = next_stage;
                     pass_d  = '0;
                  end else begin
                     inst_done   = 1'b1;
                     state_d     = IDLE;
                     imm_count_d = '0;
                     stage_d     = '0;
                     pass_d      = '0;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         stage_q     <= '0;
         pass_q      <= '0;
         imm_count_q <= '0;
         cc_ok_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         stage_q     <= stage_d;
         pass_q      <= pass_d;
         imm_count_q <= imm_count_d;
         cc_ok_q     <= cc_ok_d;
      end
   end

   assign busy       = (state_q == RUN);
   assign stage      = stage_q;
   assign pass_index = pass_q;
   assign first_pass = busy && (pass_q == '0);
   assign last_pass  = busy && (pass_q == rep_cur);

endmodule
